// File: rtl/fifo_xgmii_reader.sv
// fifo_xgmii_reader: drains a 36-bit sync_fifo into a registered 32-bit XGMII lane stream.
// It inserts idles, honours out_ready back-pressure, tracks frames and aborts underflowed frames with /E/.
module fifo_xgmii_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          xgmii_txd,
  output logic [CTRL_WIDTH-1:0]          xgmii_txc,
  output logic                           underflow,
  output logic                           frame_err,
  output logic [15:0]                    frames_sent
);

  localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [7:0] START_CH = 8'hFB;
  localparam logic [7:0] TERM_CH  = 8'hFD;
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{8'h07}};
  localparam logic [DATA_WIDTH-1:0] ERR_WORD  = {CTRL_WIDTH{8'hFE}};
  localparam logic [CTRL_WIDTH-1:0] ALL_CTRL  = {CTRL_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [WORD_W-1:0]     r_q [2];
  logic [1:0]            r_occ, w_occ_after;
  logic                  r_inflight;
  logic                  w_have, w_pop, w_push, w_start, w_term;
  logic [WORD_W-1:0]     w_word;
  logic [DATA_WIDTH-1:0] r_txd, w_txd_nxt;
  logic [CTRL_WIDTH-1:0] r_txc, w_txc_nxt;
  logic                  r_uf, w_uf_nxt;
  logic                  r_fe, w_fe_nxt;
  logic [15:0]           r_frames, w_frames_nxt;

  // At most two words are ever owed to us (queued plus the one in flight), so a return always fits.
  assign fifo_rd_en  = rst && !fifo_empty && (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2);

  assign w_have      = (r_occ != 2'd0) || r_inflight;
  assign w_word      = (r_occ != 2'd0) ? r_q[0] : fifo_rd_data;
  assign w_pop       = out_ready && (r_occ != 2'd0);
  assign w_push      = r_inflight && !(out_ready && (r_occ == 2'd0));
  assign w_occ_after = r_occ - {1'b0, w_pop};
  assign w_start     = w_word[DATA_WIDTH] && (w_word[7:0] == START_CH);

  always_comb begin
    w_term = 1'b0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (w_word[DATA_WIDTH+i] && (w_word[8*i +: 8] == TERM_CH)) w_term = 1'b1;
    end
  end

  // NOTE: the queue payload is deliberately not reset; r_occ alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (w_pop)  r_q[0] <= r_q[1];
    if (w_push) r_q[w_occ_after[0]] <= fifo_rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_occ      <= w_occ_after + {1'b0, w_push};
      r_inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (out_ready) begin
      case (r_state)
        S_IDLE:  if (w_have && w_start && !w_term) w_state_nxt = S_FRAME;
        S_FRAME: begin
          if (!w_have)     w_state_nxt = S_DROP;
          else if (w_term) w_state_nxt = S_IDLE;
        end
        S_DROP:  if (w_have && w_term) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_txd_nxt    = r_txd;
    w_txc_nxt    = r_txc;
    w_uf_nxt     = 1'b0;
    w_fe_nxt     = 1'b0;
    w_frames_nxt = r_frames;
    if (out_ready) begin
      w_txd_nxt = IDLE_WORD;
      w_txc_nxt = ALL_CTRL;
      case (r_state)
        S_IDLE: begin
          if (w_have && w_start) begin
            w_txd_nxt = w_word[DATA_WIDTH-1:0];
            w_txc_nxt = w_word[WORD_W-1:DATA_WIDTH];
            if (w_term) w_frames_nxt = r_frames + 16'd1;
          end else if (w_have) begin
            w_fe_nxt = 1'b1;
          end
        end
        S_FRAME: begin
          if (w_have) begin
            w_txd_nxt = w_word[DATA_WIDTH-1:0];
            w_txc_nxt = w_word[WORD_W-1:DATA_WIDTH];
            w_fe_nxt  = w_start;
            if (w_term) w_frames_nxt = r_frames + 16'd1;
          end else begin
            w_txd_nxt = ERR_WORD;
            w_uf_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txd    <= IDLE_WORD;
      r_txc    <= ALL_CTRL;
      r_uf     <= 1'b0;
      r_fe     <= 1'b0;
      r_frames <= 16'd0;
    end else begin
      r_txd    <= w_txd_nxt;
      r_txc    <= w_txc_nxt;
      r_uf     <= w_uf_nxt;
      r_fe     <= w_fe_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  assign xgmii_txd   = r_txd;
  assign xgmii_txc   = r_txc;
  assign underflow   = r_uf;
  assign frame_err   = r_fe;
  assign frames_sent = r_frames;

endmodule

// File: doc/fifo_xgmii_reader.md
# fifo_xgmii_reader

Drains the TX-side `sync_fifo` and drives a 32-bit XGMII-style lane stream toward the PCS.
- FIFO words are 36 bits: `[35:32]` = control flags, `[31:0]` = data; lane 0 is `[7:0]`/ctrl bit 0.
- Fills idle cycles with /I/, honours a downstream pause (`out_ready`), and tracks frame boundaries.
- Handles mid-frame FIFO underflow by emitting /E/ and discarding the remainder of the broken frame.

## Interface
- `DATA_WIDTH`, 32, data bits per FIFO word and per output word.
- `CTRL_WIDTH`, 4, control bits; must equal `DATA_WIDTH/8`.
- `clk` in 1 — single clock; all state on rising edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `fifo_empty` in 1 — `sync_fifo` empty flag.
- `fifo_rd_en` out 1 — FIFO pop request.
- `fifo_rd_data` in 36 — FIFO read data, valid the cycle after `fifo_rd_en`.
- `out_ready` in 1 — downstream accepts an output word this cycle; low = pause.
- `xgmii_txd` out 32 — output data, registered.
- `xgmii_txc` out 4 — output control, registered.
- `underflow` out 1 — one-cycle pulse when a mid-frame underflow is detected.
- `frame_err` out 1 — one-cycle pulse on a protocol violation.
- `frames_sent` out 16 — count of complete frames emitted; wraps at 0xFFFF→0.

## Operation
**Word classification**
- Start: `ctrl[0]=1` and `data[7:0]=0xFB`.
- Terminate: any lane i with `ctrl[i]=1` and byte i `=0xFD`.
- Idle word: `txd=0x07070707`, `txc=4'hF`. Error word: `txd=0xFEFEFEFE`, `txc=4'hF`.

**Local 2-entry queue plus one in-flight read**
- `fifo_rd_en = !fifo_empty && (queue_occ + inflight) < 2`. Combinational from registered state only; never depends on `out_ready` directly.
- Returned data is captured into the queue. If the queue is empty and the output advances this cycle, it bypasses straight to the output register.
- Output advances only when `out_ready=1`. When `out_ready=0`, `xgmii_txd`/`xgmii_txc` hold their value and nothing is popped.

**States**
- IDLE:
  - No word available: emit idle.
  - Start word: emit it, go to IN_FRAME. If the word is also terminate, emit it, stay in IDLE, `frames_sent++`.
  - Any other word: discard it, emit idle, pulse `frame_err`.
- IN_FRAME:
  - Word available: emit it unchanged.
  - Terminate: go to IDLE, `frames_sent++`.
  - Start word (missing terminate): emit unchanged, pulse `frame_err`, stay in IN_FRAME.
  - No word available while `out_ready=1`: emit error word, pulse `underflow`, go to DROP.
- DROP:
  - Emit idle every advancing cycle.
  - Pop and discard words.
  - On a popped terminate, go to IDLE. No `frames_sent` increment.

**Reset**
- Outputs: `xgmii_txd=0x07070707`, `xgmii_txc=4'hF`, `fifo_rd_en=0`, `underflow=0`, `frame_err=0`, `frames_sent=0`.
- Internal: state IDLE, queue empty, inflight=0.
- Reset asserted mid-frame aborts immediately. No /E/ or /T/ is emitted; the first word after release is idle.
- A FIFO read in flight at reset is discarded.

## Timing
- Latency: `fifo_rd_en` high in cycle N → data in cycle N+1 → visible on `xgmii_*` in cycle N+2, given `out_ready=1` in N+1.
- Sustained throughput is one word per cycle while `fifo_empty=0` and `out_ready=1`.
- Pause of any length loses no word; the queue absorbs the in-flight read.
- Underflow is evaluated only on cycles with `out_ready=1`. A paused cycle with an empty queue is not an underflow.
- `underflow`, `frame_err` and the `frames_sent` update are registered and coincide with the output word that caused them.

## Test plan
- **Reset:** hold `rst=0` 3 cycles, then release with FIFO empty → idle word (`0x07070707`, `txc=F`) every cycle, `fifo_rd_en=0`, all counters 0.
- **Normal frame:** FIFO holds {`0x555555FB`/`0x1`, `0x00000001`/`0x0`, `0x070707FD`/`0xF`}, `out_ready=1` → same three words emitted back-to-back, first at 2 cycles after the first `fifo_rd_en`; then idle; `frames_sent=1`.
- **Pause:** same frame with `out_ready` low for 3 cycles after the first data word → output holds `0x00000001` for 3 cycles, no word lost or duplicated, no `underflow`.
- **Underflow:** start word plus one data word, FIFO then stays empty for 2 cycles → `0xFEFEFEFE`/`F` emitted once and `underflow` pulses once. Later data words and the terminate are discarded; output stays idle; `frames_sent` is unchanged.
- **Stray data:** `0x12345678`/`0x0` pushed in IDLE → discarded, idle emitted, `frame_err` pulses once.
- **Wrap:** preload `frames_sent` to 0xFFFF via 65535 single-word frames (`0x07FD07FB`, ctrl `0x5`) then one more frame → `frames_sent=0x0000`.
